// File: rtl/t04_mem_pkg.sv
// Shared types and constants for the core-to-bus memory responder.
// Holds the controller state encoding and the default bus-ack timeout.
package t04_mem_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_BUSY = 3'd1,
        D_BUSY = 3'd2,
        DONE_I = 3'd3,
        DONE_D = 3'd4
    } t04_mem_state_t;

    localparam int T04_MEM_TIMEOUT = 255;

endpackage

// File: rtl/t04_memory_responder.sv
// Bridges core fetch/load/store requests onto a strobe/ack bus manager.
// Data requests win over fetch; a watchdog converts a missing ack into bus_err.
module t04_memory_responder
    import t04_mem_pkg::*;
#(
    parameter int TIMEOUT = T04_MEM_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] final_address,
    input  logic [31:0] mem_store,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [31:0] bus_adr,
    output logic [31:0] bus_wdata,
    output logic        bus_we,
    output logic        bus_stb,
    output logic        i_ack,
    output logic        d_ack,
    output logic [31:0] instruction_in,
    output logic [31:0] data_out,
    output logic        bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Last wait value before giving up: TIMEOUT strobe cycles in total.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    t04_mem_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      bus_adr_q, bus_adr_d;
    logic [31:0]      bus_wdata_q, bus_wdata_d;
    logic             bus_we_q, bus_we_d;
    logic             bus_stb_q, bus_stb_d;
    logic [31:0]      instruction_in_q, instruction_in_d;
    logic [31:0]      data_out_q, data_out_d;
    logic             bus_err_q, bus_err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            bus_adr_q        <= '0;
            bus_wdata_q      <= '0;
            bus_we_q         <= 1'b0;
            bus_stb_q        <= 1'b0;
            instruction_in_q <= '0;
            data_out_q       <= '0;
            bus_err_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            bus_adr_q        <= bus_adr_d;
            bus_wdata_q      <= bus_wdata_d;
            bus_we_q         <= bus_we_d;
            bus_stb_q        <= bus_stb_d;
            instruction_in_q <= instruction_in_d;
            data_out_q       <= data_out_d;
            bus_err_q        <= bus_err_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        bus_adr_d        = bus_adr_q;
        bus_wdata_d      = bus_wdata_q;
        bus_we_d         = bus_we_q;
        bus_stb_d        = bus_stb_q;
        instruction_in_d = instruction_in_q;
        data_out_d       = data_out_q;
        bus_err_d        = bus_err_q;

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bus_stb_d = 1'b1;
                bus_adr_d = final_address;
                if (MemRead || MemWrite) begin
                    bus_wdata_d = mem_store;
                    bus_we_d    = MemWrite;
                    state_d     = D_BUSY;
                end else begin
                    bus_we_d = 1'b0;
                    state_d  = I_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                if (bus_ack) begin
                    bus_stb_d = 1'b0;
                    if (state_q == I_BUSY) begin
                        instruction_in_d = bus_rdata;
                        state_d          = DONE_I;
                    end else begin
                        // Stores complete without touching the load register.
                        if (!bus_we_q) begin
                            data_out_d = bus_rdata;
                        end
                        state_d = DONE_D;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    bus_err_d = 1'b1;
                    bus_stb_d = 1'b0;
                    state_d   = (state_q == I_BUSY) ? DONE_I : DONE_D;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE_I, DONE_D: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus_adr        = bus_adr_q;
    assign bus_wdata      = bus_wdata_q;
    assign bus_we         = bus_we_q;
    assign bus_stb        = bus_stb_q;
    assign instruction_in = instruction_in_q;
    assign data_out       = data_out_q;
    assign bus_err        = bus_err_q;
    assign i_ack          = (state_q == DONE_I);
    assign d_ack          = (state_q == DONE_D);

endmodule

// File: tb/tb_t04_memory_responder.sv
// Randomized bench for t04_memory_responder: a bus-slave driver with chosen ack
// delays and a transaction-level model of what the core should observe.
module tb_t04_memory_responder;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite;
    logic [31:0] final_address, mem_store, bus_rdata;
    logic        bus_ack;
    logic [31:0] bus_adr, bus_wdata, instruction_in, data_out;
    logic        bus_we, bus_stb, i_ack, d_ack, bus_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_instr, m_data;
    logic        m_err;

    t04_memory_responder #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .final_address(final_address), .mem_store(mem_store),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .bus_adr(bus_adr), .bus_wdata(bus_wdata),
        .bus_we(bus_we), .bus_stb(bus_stb),
        .i_ack(i_ack), .d_ack(d_ack),
        .instruction_in(instruction_in), .data_out(data_out),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Entered and left at a negedge of a cycle in which the responder is idle.
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int delay, input logic [31:0] busy_addr,
                           input bit junk, input string name);
        logic is_data, exp_we;
        int   stb_cycles, exp_cycles, guard;
        bit   acked;
        is_data = rd | wr;
        exp_we  = wr;
        MemRead = rd; MemWrite = wr; final_address = addr; mem_store = wdata;
        bus_ack = junk; bus_rdata = $urandom;
        @(negedge clk);
        stb_cycles = 0;
        guard = 0;
        while (bus_stb === 1'b1 && guard < 40) begin
            stb_cycles++;
            guard++;
            checks++;
            if (bus_adr !== addr || bus_we !== exp_we || (is_data && bus_wdata !== wdata)) begin
                errors++;
                $display("FAIL %s hold c%0d: adr=%h we=%b wdata=%h required adr=%h we=%b wdata=%h",
                         name, stb_cycles, bus_adr, bus_we, bus_wdata, addr, exp_we, wdata);
            end
            MemRead = 1'($urandom); MemWrite = 1'($urandom);
            final_address = busy_addr; mem_store = $urandom;
            bus_ack = (stb_cycles == delay);
            bus_rdata = bus_ack ? rdata : $urandom;
            @(negedge clk);
        end
        acked = (delay >= 1 && delay <= TO);
        exp_cycles = acked ? delay : TO;
        if (acked) begin
            if (!is_data) m_instr = rdata;
            else if (!wr) m_data = rdata;
        end else begin
            m_err = 1'b1;
        end
        checks++;
        if (stb_cycles != exp_cycles) begin
            errors++;
            $display("FAIL %s strobe_cycles: got %0d required %0d", name, stb_cycles, exp_cycles);
        end
        checks++;
        if ({i_ack, d_ack, bus_stb} !== {~is_data, is_data, 1'b0}) begin
            errors++;
            $display("FAIL %s done: i_ack=%b d_ack=%b stb=%b required %b %b 0",
                     name, i_ack, d_ack, bus_stb, ~is_data, is_data);
        end
        checks++;
        if (instruction_in !== m_instr || data_out !== m_data || bus_err !== m_err) begin
            errors++;
            $display("FAIL %s result: instr=%h data=%h err=%b required %h %h %b",
                     name, instruction_in, data_out, bus_err, m_instr, m_data, m_err);
        end
        bus_ack = junk; bus_rdata = $urandom;
        @(negedge clk);
        checks++;
        if ({i_ack, d_ack, bus_stb} !== 3'b000 || instruction_in !== m_instr ||
            data_out !== m_data || bus_err !== m_err) begin
            errors++;
            $display("FAIL %s after: i_ack=%b d_ack=%b stb=%b instr=%h data=%h err=%b required 0 0 0 %h %h %b",
                     name, i_ack, d_ack, bus_stb, instruction_in, data_out, bus_err,
                     m_instr, m_data, m_err);
        end
        bus_ack = 1'b0;
        $display("txn %s rd=%b wr=%b adr=%h delay=%0d strobes=%0d instr=%h data=%h err=%b",
                 name, rd, wr, addr, delay, stb_cycles, instruction_in, data_out, bus_err);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0; final_address = '0; mem_store = '0;
        bus_rdata = '0; bus_ack = 1'b0;
        m_instr = '0; m_data = '0; m_err = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_stb, bus_we, i_ack, d_ack, bus_err, bus_adr, bus_wdata, instruction_in, data_out} !== '0) begin
            errors++;
            $display("FAIL reset_state: stb=%b we=%b ia=%b da=%b err=%b adr=%h wd=%h instr=%h data=%h required all 0",
                     bus_stb, bus_we, i_ack, d_ack, bus_err, bus_adr, bus_wdata, instruction_in, data_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        run_txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h0010_0093, 3, 32'h0000_0010, 1'b0, "fetch");
    endtask

    task automatic test_load();
        run_txn(1'b1, 1'b0, 32'h3300_0004, 32'h0, 32'hDEAD_BEEF, 2, 32'h0000_0044, 1'b1, "load");
    endtask

    task automatic test_store();
        run_txn(1'b0, 1'b1, 32'h3300_0008, 32'h1234_5678, 32'hCAFE_F00D, 3, 32'h0000_0048, 1'b0, "store");
    endtask

    task automatic test_min_latency();
        run_txn(1'b1, 1'b1, 32'h3300_000C, 32'hA5A5_5A5A, 32'h1111_2222, 1, 32'h0, 1'b1, "both_min");
        run_txn(1'b0, 1'b0, 32'h0000_0014, 32'h0, 32'h3333_4444, 1, 32'h0, 1'b0, "fetch_min");
    endtask

    task automatic test_stability();
        run_txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h0000_0013, 4, 32'h0000_0020, 1'b0, "stab_a");
        run_txn(1'b0, 1'b0, 32'h0000_0020, 32'h0, 32'h0000_0033, 2, 32'h0000_0020, 1'b0, "stab_b");
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 1'b0, 32'h0000_0030, 32'h0, 32'hBAD0_BAD0, 0, 32'h0, 1'b1, "timeout_i");
        run_txn(1'b1, 1'b0, 32'h3300_0010, 32'h0, 32'h5555_AAAA, 2, 32'h0, 1'b0, "after_to");
        run_txn(1'b1, 1'b0, 32'h3300_0014, 32'h0, 32'hBAD1_BAD1, 5, 32'h0, 1'b0, "timeout_d");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic rd, wr;
            int   kind;
            kind = int'($urandom_range(0, 3));
            rd = (kind == 1) || (kind == 3);
            wr = (kind == 2) || (kind == 3);
            run_txn(rd, wr, $urandom, $urandom, $urandom, int'($urandom_range(1, 6)),
                    $urandom, 1'($urandom), $sformatf("rnd%0d", n));
        end
    endtask

    task automatic test_reset_mid();
        bit saw_ack;
        MemRead = 1'b1; MemWrite = 1'b0; final_address = 32'h3300_0100; bus_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_stb !== 1'b1 || bus_adr !== 32'h3300_0100) begin
            errors++;
            $display("FAIL rstmid_busy: stb=%b adr=%h required 1 33000100", bus_stb, bus_adr);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus_stb, bus_we, i_ack, d_ack, bus_err, bus_adr, bus_wdata, instruction_in, data_out} !== '0) begin
            errors++;
            $display("FAIL rstmid_async: stb=%b ia=%b da=%b err=%b adr=%h instr=%h data=%h required all 0",
                     bus_stb, i_ack, d_ack, bus_err, bus_adr, instruction_in, data_out);
        end
        bus_ack = 1'b1;
        saw_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (i_ack || d_ack || bus_stb) saw_ack = 1'b1;
        end
        checks++;
        if (saw_ack) begin
            errors++;
            $display("FAIL rstmid_noack: activity seen=1 required 0");
        end
        m_instr = '0; m_data = '0; m_err = 1'b0;
        bus_ack = 1'b0;
        rst = 1'b0;
        run_txn(1'b0, 1'b1, 32'h3300_0200, 32'h7777_8888, 32'h0, 2, 32'h0, 1'b0, "post_rst");
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_load();
        test_store();
        test_min_latency();
        test_stability();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
